// File: rtl/ex_stage.sv
// Execute stage of the 64-bit ARM pipeline.
// Computes the ALU or MOVZ/MOVK result, keeps the NZVC flag register,
// drives same-cycle forwarding data back to decode, and registers what
// the memory stage needs into the EX/MEM pipeline register.
// There is no valid/ready handshake: the pipeline register captures
// every cycle, and bubbles travel as NOOP=1.
// Gate delays are a simulation-only notion and are not modelled here.
module ex_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUA,
    input  logic [WIDTH-1:0] ALUB,
    input  logic [WIDTH-1:0] Db,
    input  logic [31:0]      OPCode,
    input  logic [2:0]       ALUCntrl,
    input  logic             MemWrite,
    input  logic             MOVZ,
    input  logic             MOVK,
    input  logic             LDURB,
    input  logic             Mem2Reg,
    input  logic             RegWrite,
    input  logic             read_enable,
    input  logic             NOOP,
    input  logic             SetFlags,
    input  logic [3:0]       xfer_size,
    output logic [WIDTH-1:0] ExForward,
    output logic [4:0]       ExRd,
    output logic             ExRegWrite,
    output logic [3:0]       FlagsFwd,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] MemData,
    output logic [4:0]       Rd,
    output logic             MemWriteOut,
    output logic             LDURBOut,
    output logic             Mem2RegOut,
    output logic             RegWriteOut,
    output logic             read_enableOut,
    output logic             NOOPOut,
    output logic [3:0]       xfer_sizeOut
);

    // Shared adder: subtract is A + ~B + 1, so one carry chain serves both.
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_carry_into_msb;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [15:0]      w_imm16;
    logic [1:0]       w_hw;
    logic [WIDTH-1:0] w_movz_res;
    logic [WIDTH-1:0] w_movk_res;
    logic [WIDTH-1:0] w_result;
    logic [3:0]       w_alu_flags;
    logic             w_flag_update;

    logic [3:0]       r_flags;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_mem_data;
    logic [4:0]       r_rd;
    logic             r_mem_write;
    logic             r_ldurb;
    logic             r_mem2reg;
    logic             r_reg_write;
    logic             r_read_enable;
    logic             r_noop;
    logic [3:0]       r_xfer_size;

    assign w_b_eff = (ALUCntrl == 3'b011) ? ~ALUB : ALUB;
    assign w_cin   = (ALUCntrl == 3'b011);
    assign w_sum   = {1'b0, ALUA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    assign w_carry_into_msb = ALUA[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_sum[WIDTH-1];

    // ALU operation select; C and V are only meaningful for add/subtract.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (ALUCntrl)
            3'b000: w_alu_res = ALUB;
            3'b010, 3'b011: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = w_carry_into_msb ^ w_sum[WIDTH];
            end
            3'b100: w_alu_res = ALUA & ALUB;
            3'b101: w_alu_res = ALUA | ALUB;
            3'b110: w_alu_res = ALUA ^ ALUB;
            default: w_alu_res = '0;
        endcase
    end

    assign w_imm16 = OPCode[20:5];
    assign w_hw    = OPCode[22:21];

    // MOVZ places imm16 in the selected halfword; MOVK patches it into Db.
    always_comb begin
        w_movz_res = '0;
        w_movk_res = Db;
        case (w_hw)
            2'd0: begin
                w_movz_res[15:0]  = w_imm16;
                w_movk_res[15:0]  = w_imm16;
            end
            2'd1: begin
                w_movz_res[31:16] = w_imm16;
                w_movk_res[31:16] = w_imm16;
            end
            2'd2: begin
                w_movz_res[47:32] = w_imm16;
                w_movk_res[47:32] = w_imm16;
            end
            default: begin
                w_movz_res[63:48] = w_imm16;
                w_movk_res[63:48] = w_imm16;
            end
        endcase
    end

    assign w_result = MOVZ ? w_movz_res : (MOVK ? w_movk_res : w_alu_res);

    // Flags are derived from the ALU result; moves never reach the flag register.
    assign w_alu_flags   = {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_v, w_alu_c};
    assign w_flag_update = SetFlags & ~NOOP & ~MOVZ & ~MOVK;

    assign ExForward  = w_result;
    assign ExRd       = OPCode[4:0];
    assign ExRegWrite = RegWrite & ~NOOP;
    assign FlagsFwd   = w_flag_update ? w_alu_flags : r_flags;

    // NZVC flag register: loads on a flag-setting, non-bubble ALU op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_flag_update) begin
            r_flags <= w_alu_flags;
        end
    end

    // EX/MEM pipeline register; a bubble suppresses all side effects.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result      <= '0;
            r_mem_data    <= '0;
            r_rd          <= '0;
            r_mem_write   <= 1'b0;
            r_ldurb       <= 1'b0;
            r_mem2reg     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_read_enable <= 1'b0;
            r_noop        <= 1'b0;
            r_xfer_size   <= 4'b0000;
        end else begin
            r_result      <= w_result;
            r_mem_data    <= Db;
            r_rd          <= OPCode[4:0];
            r_mem_write   <= MemWrite & ~NOOP;
            r_ldurb       <= LDURB;
            r_mem2reg     <= Mem2Reg;
            r_reg_write   <= RegWrite & ~NOOP;
            r_read_enable <= read_enable & ~NOOP;
            r_noop        <= NOOP;
            r_xfer_size   <= xfer_size;
        end
    end

    assign Flags          = r_flags;
    assign Result         = r_result;
    assign MemData        = r_mem_data;
    assign Rd             = r_rd;
    assign MemWriteOut    = r_mem_write;
    assign LDURBOut       = r_ldurb;
    assign Mem2RegOut     = r_mem2reg;
    assign RegWriteOut    = r_reg_write;
    assign read_enableOut = r_read_enable;
    assign NOOPOut        = r_noop;
    assign xfer_sizeOut   = r_xfer_size;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for the execute stage: hand-computed vectors for the ALU,
// flags, moves, bubbles, forwarding outputs and reset behaviour.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic [63:0] ALUA, ALUB, Db;
  logic [31:0] OPCode;
  logic [2:0]  ALUCntrl;
  logic        MemWrite, MOVZ, MOVK, LDURB, Mem2Reg, RegWrite, read_enable, NOOP, SetFlags;
  logic [3:0]  xfer_size;
  logic [63:0] ExForward;
  logic [4:0]  ExRd;
  logic        ExRegWrite;
  logic [3:0]  FlagsFwd, Flags;
  logic [63:0] Result, MemData;
  logic [4:0]  Rd;
  logic        MemWriteOut, LDURBOut, Mem2RegOut, RegWriteOut, read_enableOut, NOOPOut;
  logic [3:0]  xfer_sizeOut;

  int n_checks;
  int n_errors;

  ex_stage dut (
    .clk(clk), .reset(reset), .ALUA(ALUA), .ALUB(ALUB), .Db(Db), .OPCode(OPCode),
    .ALUCntrl(ALUCntrl), .MemWrite(MemWrite), .MOVZ(MOVZ), .MOVK(MOVK), .LDURB(LDURB),
    .Mem2Reg(Mem2Reg), .RegWrite(RegWrite), .read_enable(read_enable), .NOOP(NOOP),
    .SetFlags(SetFlags), .xfer_size(xfer_size), .ExForward(ExForward), .ExRd(ExRd),
    .ExRegWrite(ExRegWrite), .FlagsFwd(FlagsFwd), .Flags(Flags), .Result(Result),
    .MemData(MemData), .Rd(Rd), .MemWriteOut(MemWriteOut), .LDURBOut(LDURBOut),
    .Mem2RegOut(Mem2RegOut), .RegWriteOut(RegWriteOut), .read_enableOut(read_enableOut),
    .NOOPOut(NOOPOut), .xfer_sizeOut(xfer_sizeOut)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clr_inputs();
    ALUA = '0; ALUB = '0; Db = '0; OPCode = '0; ALUCntrl = 3'b000;
    MemWrite = 0; MOVZ = 0; MOVK = 0; LDURB = 0; Mem2Reg = 0; RegWrite = 0;
    read_enable = 0; NOOP = 0; SetFlags = 0; xfer_size = 4'b0000;
  endtask

  task automatic alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic sf);
    clr_inputs();
    ALUCntrl = op; ALUA = a; ALUB = b; SetFlags = sf;
  endtask

  // advance one edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr_inputs();
    reset = 1'b1;
    #2;

    // reset with flag-setting, writing instruction present
    alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    RegWrite = 1; MemWrite = 1; read_enable = 1; NOOP = 1; LDURB = 1; xfer_size = 4'hF;
    step();
    check("rst_flags", Flags, 4'b0000);
    check("rst_result", Result, 64'd0);
    check("rst_regwr", RegWriteOut, 1'b0);
    check("rst_memwr", MemWriteOut, 1'b0);
    check("rst_noop", NOOPOut, 1'b0);
    check("rst_ldurb", LDURBOut, 1'b0);
    check("rst_xfer", xfer_sizeOut, 4'h0);
    reset = 1'b0;

    // signed overflow on add
    alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    #1;
    check("ovf_fwd_flags", FlagsFwd, 4'b1010);
    step();
    check("ovf_result", Result, 64'h8000_0000_0000_0000);
    check("ovf_flags", Flags, 4'b1010);

    // equal subtract: zero with carry (no borrow)
    alu(3'b011, 64'd5, 64'd5, 1'b1);
    #1;
    check("sub0_fwd_flags", FlagsFwd, 4'b0101);
    check("sub0_fwd", ExForward, 64'd0);
    step();
    check("sub0_result", Result, 64'd0);
    check("sub0_flags", Flags, 4'b0101);

    // flags hold when SetFlags=0
    alu(3'b010, 64'd1, 64'd1, 1'b0);
    #1;
    check("hold_fwd", ExForward, 64'd2);
    check("hold_fwd_flags", FlagsFwd, 4'b0101);
    step();
    check("hold_result", Result, 64'd2);
    check("hold_flags", Flags, 4'b0101);

    // bubble: SetFlags ignored, side effects killed, data still captured
    alu(3'b010, 64'd1, 64'd1, 1'b1);
    NOOP = 1; RegWrite = 1; MemWrite = 1; read_enable = 1; Db = 64'hAA;
    #1;
    check("noop_exregwr", ExRegWrite, 1'b0);
    check("noop_fwd_flags", FlagsFwd, 4'b0101);
    step();
    check("noop_flags", Flags, 4'b0101);
    check("noop_regwr", RegWriteOut, 1'b0);
    check("noop_memwr", MemWriteOut, 1'b0);
    check("noop_rden", read_enableOut, 1'b0);
    check("noop_out", NOOPOut, 1'b1);
    check("noop_result", Result, 64'd2);
    check("noop_memdata", MemData, 64'hAA);

    // MOVZ, hw=2; ALU operands chosen so ALU flags would differ
    alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    MOVZ = 1; OPCode = {9'd0, 2'd2, 16'hBEEF, 5'd3};
    #1;
    check("movz_fwd_flags", FlagsFwd, 4'b0101);
    step();
    check("movz_result", Result, 64'h0000_BEEF_0000_0000);
    check("movz_flags", Flags, 4'b0101);

    // MOVK, hw=1
    alu(3'b011, 64'd3, 64'd5, 1'b1);
    MOVK = 1; Db = 64'h1111_2222_3333_4444; OPCode = {9'd0, 2'd1, 16'hABCD, 5'd4};
    step();
    check("movk_result", Result, 64'h1111_2222_ABCD_4444);
    check("movk_flags", Flags, 4'b0101);

    // MOVZ and MOVK together: MOVZ wins
    clr_inputs();
    MOVZ = 1; MOVK = 1; Db = 64'hFFFF_FFFF_FFFF_FFFF; OPCode = {9'd0, 2'd3, 16'h1234, 5'd0};
    #1;
    check("movzk_fwd", ExForward, 64'h1234_0000_0000_0000);

    // remaining ALU encodings, combinational
    alu(3'b101, 64'hF0, 64'h0F, 1'b0);
    #1;
    check("or_fwd", ExForward, 64'hFF);
    alu(3'b110, 64'hFF, 64'h0F, 1'b0);
    #1;
    check("xor_fwd", ExForward, 64'hF0);
    alu(3'b000, 64'h55, 64'h1234_5678, 1'b0);
    #1;
    check("pass_fwd", ExForward, 64'h1234_5678);
    alu(3'b111, 64'h55, 64'h66, 1'b0);
    #1;
    check("op111_fwd", ExForward, 64'd0);
    alu(3'b001, 64'h55, 64'h66, 1'b0);
    #1;
    check("op001_fwd", ExForward, 64'd0);

    // AND with forwarding/hazard outputs
    alu(3'b100, 64'hF0F0, 64'hFF00, 1'b0);
    OPCode = 32'd7; RegWrite = 1;
    #1;
    check("and_fwd", ExForward, 64'hF000);
    check("and_exrd", ExRd, 5'd7);
    check("and_exregwr", ExRegWrite, 1'b1);
    step();
    check("and_rd", Rd, 5'd7);
    check("and_regwr", RegWriteOut, 1'b1);
    check("and_result", Result, 64'hF000);

    // store-style pass-through
    clr_inputs();
    MemWrite = 1; Db = 64'h1234; xfer_size = 4'b1000; LDURB = 1; Mem2Reg = 1; read_enable = 1;
    step();
    check("st_memwr", MemWriteOut, 1'b1);
    check("st_memdata", MemData, 64'h1234);
    check("st_xfer", xfer_sizeOut, 4'b1000);
    check("st_ldurb", LDURBOut, 1'b1);
    check("st_mem2reg", Mem2RegOut, 1'b1);
    check("st_rden", read_enableOut, 1'b1);

    // subtract with borrow: 3 - 5, C=0, N=1
    alu(3'b011, 64'd3, 64'd5, 1'b1);
    #1;
    check("borrow_fwd_flags", FlagsFwd, 4'b1000);
    step();
    check("borrow_result", Result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("borrow_flags", Flags, 4'b1000);

    // reset mid-stream
    alu(3'b010, 64'd1, 64'd2, 1'b1);
    RegWrite = 1;
    step();
    check("pre_rst_result", Result, 64'd3);
    check("pre_rst_flags", Flags, 4'b0000);
    alu(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    RegWrite = 1; MemWrite = 1; Db = 64'h99; OPCode = 32'd9;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_result", Result, 64'd0);
    check("mid_rst_flags", Flags, 4'b0000);
    check("mid_rst_regwr", RegWriteOut, 1'b0);
    check("mid_rst_memwr", MemWriteOut, 1'b0);
    check("mid_rst_memdata", MemData, 64'd0);
    check("mid_rst_rd", Rd, 5'd0);
    alu(3'b010, 64'd3, 64'd4, 1'b0);
    RegWrite = 1;
    step();
    check("post_rst_result", Result, 64'd7);
    check("post_rst_regwr", RegWriteOut, 1'b1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
